// File: rtl/wb_sched_pkg.sv
// Shared widths and the pending-write entry type for the writeback port scheduler.
package wb_sched_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREGS  = 2 ** ADDR_W;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending load-write queue: circular buffer with per-entry squash and a
// pending-register mask derived only from registered queue state.
module wb_pend_fifo
    import wb_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  wb_entry_t         push_entry,
    input  logic              pop,
    input  logic              squash_en,
    input  logic [ADDR_W-1:0] squash_rd,
    output wb_entry_t         head,
    output logic              empty,
    output logic              full,
    output logic [NREGS-1:0]  pend_mask
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] offset;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Squash is applied before the push so a freshly written slot keeps its valid bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_en && (mem[i].rd == squash_rd)) begin
                    mem[i].valid <= 1'b0;
                end
            end
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A slot is occupied when its distance from the head is below the count.
    always_comb begin
        pend_mask = '0;
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if (({1'b0, offset} < count) && mem[i].valid) begin
                pend_mask[mem[i].rd] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_scheduler.sv
// Arbitrates the single register-file write port between pipeline writeback
// (always wins) and queued load writes, with starvation-driven stall requests.
module wb_port_scheduler
    import wb_sched_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pipe_regWrite,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stall_req,
    output logic [NREGS-1:0]  pend_mask,
    output logic              err_stall
);

    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t         head;
    wb_entry_t         push_entry;
    logic              empty;
    logic              full;
    logic              head_valid;
    logic              push;
    logic              pop;
    logic [WAIT_W-1:0] wait_cnt;

    assign ld_ready   = !full;
    assign head_valid = !empty && head.valid;
    // A load matching a same-cycle pipeline write is older, so it is dropped after handshake.
    assign push       = ld_valid && ld_ready && !(pipe_regWrite && (ld_rd == pipe_rd));
    assign pop        = !empty && (!head.valid || !pipe_regWrite);
    assign push_entry = wb_entry_t'{valid: 1'b1, rd: ld_rd, data: ld_data};

    wb_pend_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .squash_en  (pipe_regWrite),
        .squash_rd  (pipe_rd),
        .head       (head),
        .empty      (empty),
        .full       (full),
        .pend_mask  (pend_mask)
    );

    // Write-port grant, starvation counter and stall/error flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            stall_req <= 1'b0;
            err_stall <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            rf_we     <= pipe_regWrite || head_valid;
            stall_req <= 1'b0;
            if (pipe_regWrite) begin
                rf_waddr <= pipe_rd;
                rf_wdata <= pipe_data;
            end else if (head_valid) begin
                rf_waddr <= head.rd;
                rf_wdata <= head.data;
            end
            if (head_valid && pipe_regWrite) begin
                if (wait_cnt == WAIT_W'(STARVE_LIMIT - 1)) begin
                    stall_req <= 1'b1;
                    wait_cnt  <= '0;
                end else begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end else if (head_valid) begin
                wait_cnt <= '0;
            end
            if (stall_req && pipe_regWrite) begin
                err_stall <= 1'b1;
            end
        end
    end

endmodule
